// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and word type for the program loader
package loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, START, DATA, CSUM, DRAIN, END} state_t;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs accepted UART bytes big-endian into 32-bit words
module byte_assembler
  import loader_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output word_t      word,
  output logic       word_ready
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  // The word is complete combinationally on the 4th byte so the caller can register it on that edge.
  always_comb begin
    idx_d      = idx_q;
    shift_d    = shift_q;
    word       = {shift_q, rx_data};
    word_ready = rx_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
    if (clear) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (rx_valid) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], rx_data};
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - parses header + big-endian words from uart_rx and drives the fetch loader
// Optional trailing checksum word: PROGRAM_LOADER_CHECKSUM_EN
module program_loader
  import loader_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int END_DELAY   = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   input_start,
  output logic                   input_end,
  output logic [31:0]            input_data,
  output logic                   input_valid,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] words_loaded,
  output logic                   overrun,
  output logic                   checksum_error
);

  localparam int DW = $clog2(END_DELAY + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] wl_q, wl_d;
  word_t                  data_q, data_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   overrun_q, overrun_d;
  logic                   accept, clear, word_ready, last_word;
  word_t                  word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  word_t                  sum_q, sum_d;
  logic                   cerr_q, cerr_d;
`endif

  assign accept    = rx_valid && (state_q inside {IDLE, HDR, DATA, CSUM});
  assign clear     = state_q inside {START, DRAIN, END};
  assign last_word = (wl_q + 1'b1) == count_q;

  byte_assembler u_asm (
    .CLK        (CLK),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (accept),
    .clear      (clear),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wl_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      drain_q   <= '0;
      overrun_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      cerr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wl_q      <= wl_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      drain_q   <= drain_d;
      overrun_q <= overrun_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      cerr_q    <= cerr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (rx_valid) state_d = HDR;
      HDR:   if (word_ready) state_d = START;
      START: state_d = (count_q == '0) ? DRAIN : DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      DATA:  if (word_ready && last_word) state_d = CSUM;
      CSUM:  if (word_ready) state_d = DRAIN;
`else
      DATA:  if (word_ready && last_word) state_d = DRAIN;
`endif
      DRAIN: if (drain_q == DW'(END_DELAY)) state_d = END;
      END:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An empty load counts the START cycle as its first idle cycle so input_end lands END_DELAY+1 after input_start.
  always_comb begin
    count_d   = count_q;
    wl_d      = wl_q;
    data_d    = data_q;
    valid_d   = valid_q;
    drain_d   = drain_q;
    overrun_d = overrun_q | (rx_valid && !accept);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    cerr_d    = cerr_q;
`endif
    case (state_q)
      HDR: if (word_ready) begin
        count_d = (word[31:COUNT_WIDTH] != '0) ? COUNT_MAX : word[COUNT_WIDTH-1:0];
        wl_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      START: drain_d = (count_q == '0) ? DW'(1) : '0;
      DATA: if (word_ready) begin
        data_d  = word;
        valid_d = ~valid_q;
        wl_d    = wl_q + 1'b1;
        drain_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + word;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: if (word_ready) begin
        drain_d = '0;
        if (word != sum_q) cerr_d = 1'b1;
      end
`endif
      DRAIN: drain_d = drain_q + DW'(1);
      default: ;
    endcase
  end

  always_comb begin
    input_start  = (state_q == START);
    input_end    = (state_q == END);
    busy         = (state_q != IDLE);
    input_data   = data_q;
    input_valid  = valid_q;
    words_loaded = wl_q;
    overrun      = overrun_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checksum_error = cerr_q;
`else
    checksum_error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader
module tb_program_loader;

  localparam int ED = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        input_start, input_end, input_valid, busy, overrun, checksum_error;
  logic [31:0] input_data;
  logic [15:0] words_loaded;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          tog_cyc = 0;
  int          ecyc, s0;
  logic        prev_valid = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] stim_q[$];

  program_loader #(.COUNT_WIDTH(16), .END_DELAY(ED)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .input_start    (input_start),
    .input_end      (input_end),
    .input_data     (input_data),
    .input_valid    (input_valid),
    .busy           (busy),
    .words_loaded   (words_loaded),
    .overrun        (overrun),
    .checksum_error (checksum_error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (input_valid !== prev_valid) begin
        got_q.push_back(input_data);
        tog_cyc <= cyc;
      end
      prev_valid <= input_valid;
      if (input_start === 1'b1) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
      end
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_load(input logic [31:0] hdr);
    logic [31:0] sum;
    sum = '0;
    send_word(hdr);
    foreach (stim_q[i]) begin
      exp_q.push_back(stim_q[i]);
      sum = sum + stim_q[i];
      send_word(stim_q[i]);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (stim_q.size() != 0) send_word(sum);
`endif
  endtask

  task automatic wait_end(input string tag, output int end_cycle);
    logic seen;
    seen = 1'b0;
    end_cycle = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (input_end === 1'b1) begin
        seen = 1'b1;
        end_cycle = cyc;
      end
    end
    chk1(tag, seen, 1'b1);
  endtask

  task automatic check_words(input string tag);
    chk32({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0)
      chk32(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", input_valid, 1'b0);
    chk32("rst_data", input_data, 32'h0);
    chk32("rst_wl", 32'(words_loaded), 32'h0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_start", input_start, 1'b0);
    chk1("rst_end", input_end, 1'b0);
    chk1("rst_cerr", checksum_error, 1'b0);
    reset = 1'b1;
    @(negedge CLK);

    // Two-word load
    stim_q = '{32'hDEADBEEF, 32'h00000013};
    s0 = start_cnt;
    send_load(32'd2);
    wait_end("t1_end_seen", ecyc);
    chk32("t1_starts", start_cnt - s0, 1);
    check_words("t1_word");
    chk32("t1_end_gap", ecyc - tog_cyc, ED + 1);
    chk32("t1_wl", 32'(words_loaded), 32'd2);
    chk1("t1_valid", input_valid, 1'b0);
    @(negedge CLK);
    chk1("t1_busy_after", busy, 1'b0);

    // Empty load
    stim_q.delete();
    s0 = start_cnt;
    send_load(32'd0);
    wait_end("t2_end_seen", ecyc);
    chk32("t2_starts", start_cnt - s0, 1);
    check_words("t2_word");
    chk32("t2_end_gap", ecyc - start_cyc, ED + 1);
    @(negedge CLK);
    chk1("t2_busy_after", busy, 1'b0);
    chk1("t2_overrun", overrun, 1'b0);

    // Stray byte during DRAIN
    stim_q = '{32'h12345678};
    send_load(32'd1);
    send_byte(8'hA5);
    wait_end("t4_end_seen", ecyc);
    check_words("t4_word");
    chk1("t4_overrun", overrun, 1'b1);
    chk32("t4_wl", 32'(words_loaded), 32'd1);
    chk1("t4_valid", input_valid, 1'b1);

    // Asynchronous reset in the middle of a 3-word load
    send_word(32'd3);
    send_byte(8'hDE);
    send_byte(8'hAD);
    chk1("t3_busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("t3_busy", busy, 1'b0);
    chk1("t3_valid", input_valid, 1'b0);
    chk32("t3_data", input_data, 32'h0);
    chk32("t3_wl", 32'(words_loaded), 32'h0);
    chk1("t3_overrun", overrun, 1'b0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    got_q.delete();
    stim_q = '{32'hCAFEF00D};
    send_load(32'd1);
    wait_end("t3_end_seen", ecyc);
    check_words("t3_word");
    chk1("t3_valid_after", input_valid, 1'b1);

    // Oversized header saturates instead of truncating
    stim_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_load(32'h00010000);
    repeat (4) @(negedge CLK);
    check_words("t5_word");
    chk32("t5_wl", 32'(words_loaded), 32'd3);
    chk1("t5_busy", busy, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    got_q.delete();
    exp_q = '{32'h1, 32'h2};
    send_word(32'd2); send_word(32'h1); send_word(32'h2); send_word(32'h3);
    wait_end("cs_good_end", ecyc);
    check_words("cs_good_word");
    chk1("cs_good_err", checksum_error, 1'b0);
    exp_q = '{32'h1, 32'h2};
    @(negedge CLK);
    send_word(32'd2); send_word(32'h1); send_word(32'h2); send_word(32'h4);
    wait_end("cs_bad_end", ecyc);
    check_words("cs_bad_word");
    chk1("cs_bad_err", checksum_error, 1'b1);
`else
    chk1("cerr_tied", checksum_error, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
